// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared constants, state encoding and channel helpers for adc_seq_ctrl
package adc_seq_pkg;

    localparam int NUM_CHAN    = 8;
    localparam int FRAME_BITS  = 16;
    localparam int DATA_W      = 12;
    localparam int CHAN_W      = 3;
    localparam int HOLD_TICKS  = 2;
    localparam int TIMEOUT_CYC = 1024;

    // Frame bit positions of the channel address (MSB first) and of the result field
    localparam int ADDR_MSB = 2;
    localparam int ADDR_LSB = 4;
    localparam int DATA_LSB = 4;
    localparam int DATA_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    function automatic logic [CHAN_W-1:0] lowest_chan(input logic [NUM_CHAN-1:0] mask);
        logic [CHAN_W-1:0] ch;
        ch = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--)
            if (mask[i]) ch = CHAN_W'(i);
        return ch;
    endfunction

    // {found, channel}: lowest enabled channel strictly above cur
    function automatic logic [CHAN_W:0] next_chan(input logic [NUM_CHAN-1:0] mask,
                                                  input logic [CHAN_W-1:0]   cur);
        logic [CHAN_W:0] r;
        r = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--)
            if (mask[i] && i > int'(cur)) r = {1'b1, CHAN_W'(i)};
        return r;
    endfunction

    function automatic logic frame_din(input logic [CHAN_W-1:0] addr, input int bit_idx);
        logic bit_val;
        bit_val = 1'b0;
        for (int i = 0; i < CHAN_W; i++)
            if (bit_idx == ADDR_LSB - i) bit_val = addr[i];
        return bit_val;
    endfunction

endpackage

// File: rtl/adc_seq_edge_sync.sv
// rtl/adc_seq_edge_sync.sv - div_clk synchroniser with registered rise/fall strobes
module adc_seq_edge_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic div_clk,
    output logic div_lvl,
    output logic rise,
    output logic fall
);

    logic sync_1, sync_2, last;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            last   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= div_clk;
            sync_2 <= sync_1;
            last   <= sync_2;
            rise   <= sync_2 & ~last;
            fall   <= ~sync_2 & last;
        end
    end

    assign div_lvl = sync_2;

endmodule

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - 8-channel serial ADC sweep sequencer; ADC_SEQ_STALL_TIMEOUT_EN adds a stall watchdog
module adc_seq_ctrl
    import adc_seq_pkg::*;
(
    input  logic                clk_in,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [NUM_CHAN-1:0] chan_mask,
    input  logic [1:0]          freq_sel,
    input  logic                div_clk,
    output logic                div_enable,
    output logic                div_freq_a,
    output logic                div_freq_b,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_din,
    input  logic                adc_dout,
    output logic [DATA_W-1:0]   sample_data,
    output logic [CHAN_W-1:0]   sample_chan,
    output logic                sample_valid,
    output logic                busy,
    output logic                err
);

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_TICKS - 1);

    seq_state_t          state_q, state_d;
    logic [NUM_CHAN-1:0] mask_q;
    logic [1:0]          freq_q;
    logic [CHAN_W-1:0]   addr_q, rpt_q, nxt_chan;
    logic                dummy_q, last_q, nxt_found;
    logic [CNT_W-1:0]    bit_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [DATA_W-2:0]   shreg;
    logic                div_lvl, rise, fall, timeout;
    logic                accept, relatch, err_set, frame_end, hold_done;

    adc_seq_edge_sync u_edge_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .div_clk (div_clk),
        .div_lvl (div_lvl),
        .rise    (rise),
        .fall    (fall)
    );

    assign {nxt_found, nxt_chan} = next_chan(mask_q, addr_q);
    assign {div_freq_a, div_freq_b} = freq_q;

`ifdef ADC_SEQ_STALL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state_q == ST_IDLE || rise || fall)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        relatch    = 1'b0;
        err_set    = 1'b0;
        frame_end  = 1'b0;
        hold_done  = 1'b0;
        div_enable = 1'b1;
        busy       = 1'b1;
        adc_cs_n   = 1'b1;
        adc_sclk   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                div_enable = 1'b0;
                busy       = 1'b0;
                if (start) begin
                    if (chan_mask != '0) begin
                        accept  = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (fall) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = div_lvl;
                if (rise && bit_cnt == LAST_BIT) begin
                    frame_end = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rise && hold_cnt == LAST_HOLD) begin
                    hold_done = 1'b1;
                    if (!last_q) begin
                        state_d = ST_SHIFT;
                    end else if (continuous) begin
                        relatch = 1'b1;
                        if (chan_mask != '0) begin
                            state_d = ST_SHIFT;
                        end else begin
                            err_set = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mask_q       <= '0;
            freq_q       <= '0;
            addr_q       <= '0;
            rpt_q        <= '0;
            dummy_q      <= 1'b0;
            last_q       <= 1'b0;
            bit_cnt      <= '0;
            hold_cnt     <= '0;
            shreg        <= '0;
            adc_din      <= 1'b0;
            sample_data  <= '0;
            sample_chan  <= '0;
            sample_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state_q == ST_IDLE)
                freq_q <= freq_sel;

            if (err_set)
                err <= 1'b1;
            else if (accept)
                err <= 1'b0;

            // Every sweep opens with a dummy frame addressing the lowest enabled channel
            if (accept || relatch) begin
                mask_q  <= chan_mask;
                addr_q  <= lowest_chan(chan_mask);
                dummy_q <= 1'b1;
                last_q  <= 1'b0;
            end else if (hold_done && !last_q) begin
                rpt_q   <= addr_q;
                dummy_q <= 1'b0;
                addr_q  <= nxt_found ? nxt_chan : lowest_chan(mask_q);
                last_q  <= !nxt_found;
            end

            if (state_q == ST_SHIFT) begin
                if (rise) begin
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    shreg   <= {shreg[DATA_W-3:0], adc_dout};
                end
                if (fall)
                    adc_din <= frame_din(addr_q, int'(bit_cnt));
            end else begin
                bit_cnt <= '0;
                adc_din <= 1'b0;
            end

            if (state_q == ST_HOLD) begin
                if (rise)
                    hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if (frame_end && !dummy_q) begin
                sample_valid <= 1'b1;
                sample_chan  <= rpt_q;
                sample_data  <= {shreg, adc_dout};
            end
        end
    end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Conversion sequencer for the 8-channel serial ADC front end (ADC128S022-style, 16-clock frames, 12-bit result).
- Configures and enables the system clock divider, and uses the divided clock as SCLK.
- Frames chip-select, shifts the channel address out and the data in, sweeps the enabled channels in ascending order, and presents tagged samples to the downstream datapath.

Parameters:
- FRAME_BITS, 16, SCLK periods per CS-low frame.
- DATA_W, 12, conversion result width (frame bits 4..15).
- CHAN_W, 3, channel address width (frame bits 2..4, MSB first).
- HOLD_TICKS, 2, divided-clock rising edges with CS high between frames.
- TIMEOUT_CYC, 1024, clk_in cycles without a divided-clock edge before a stall error (optional feature only).

Ports:
- clk_in  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a sweep when IDLE.
- continuous  in  1  1 = restart the sweep automatically; sampled at each sweep end.
- chan_mask  in  8  enabled channels; latched at sweep start.
- freq_sel  in  2  divider rate request; latched in IDLE only.
- div_clk  in  1  divided clock from the divider (asynchronous to clk_in).
- div_enable  out  1  divider enable.
- div_freq_a  out  1  divider select MSB.
- div_freq_b  out  1  divider select LSB.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_sclk  out  1  ADC serial clock.
- adc_din  out  1  address to ADC.
- adc_dout  in  1  data from ADC.
- sample_data  out  DATA_W  conversion result.
- sample_chan  out  CHAN_W  channel of sample_data.
- sample_valid  out  1  one-cycle pulse.
- busy  out  1  high from start acceptance until return to IDLE.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0, except adc_cs_n=1 and adc_sclk=1. State=IDLE; latched mask/freq cleared.
- div_clk synchronisation: 2-FF synchroniser plus edge register gives single-cycle rise and fall strobes in the clk_in domain. The edge detector output lags div_clk by 3 clk_in cycles.
- States: IDLE → ARM → SHIFT → HOLD → (SHIFT | IDLE).
- IDLE:
  - div_enable=0; {div_freq_a,div_freq_b} follow freq_sel.
  - start with chan_mask≠0: latch mask, busy=1, err=0, go to ARM.
  - start with chan_mask=0: ignored, err=1.
- ARM:
  - div_enable=1.
  - Wait for the first fall strobe, then drive adc_cs_n=0 and go to SHIFT. This gives CS setup ≥ half an SCLK period.
- SHIFT:
  - adc_sclk = synchronised div_clk.
  - Bit counter 0..FRAME_BITS-1 advances on each rise strobe.
  - adc_din updates on the fall strobe: address bits at counter 2,3,4, all other bits 0.
  - adc_dout is sampled on the rise strobe into a shift register, MSB first; bits 4..15 form the result.
  - After rise #16: adc_cs_n=1, adc_sclk=1, go to HOLD.
- Pipelined addressing:
  - Frame N converts the channel addressed in frame N-1.
  - Each sweep begins with one dummy frame addressing the lowest enabled channel. Its data is discarded and no sample_valid is issued.
  - Total frames per sweep = popcount(mask)+1.
  - Each later frame addresses the next enabled channel and reports the previously addressed one.
  - The final frame addresses the lowest enabled channel again (don't care).
- Output: sample_valid pulses 1 clk_in cycle after the frame's last rise strobe, with sample_chan/sample_data stable until the next pulse.
- HOLD: wait HOLD_TICKS rise strobes, then:
  - more frames remain → SHIFT with adc_cs_n=0;
  - sweep done and continuous=1 → relatch chan_mask and start a new sweep (dummy frame included); a newly latched chan_mask=0 sets err=1 and goes to IDLE;
  - sweep done and continuous=0 → IDLE, busy=0, div_enable=0.
- Mid-operation events:
  - start while busy: ignored.
  - Changes to chan_mask or freq_sel mid-sweep: no effect.
  - continuous deasserted mid-sweep: the current sweep completes.
- Asynchronous reset mid-frame: CS returns high at once and the partial frame is discarded.
- Single-channel mask: 2 frames per sweep.

Optional Feature:
- ADC_SEQ_STALL_TIMEOUT_EN, defined: a watchdog counts clk_in cycles since the last div_clk edge while in ARM/SHIFT/HOLD. When it reaches TIMEOUT_CYC: err=1, adc_cs_n=1, div_enable=0, busy=0, go to IDLE.
- Not defined: no watchdog logic; TIMEOUT_CYC unused.

Decomposition:
- Package adc_seq_pkg: state encoding constants, FRAME_BITS, DATA_W, CHAN_W, address bit positions (2..4), data field LSB/MSB (4/15).
- Sub-module adc_seq_edge_sync: 2-FF synchroniser plus rise/fall strobe generator for div_clk.

Test Plan:
- mask=8'b0000_0100, freq_sel=2'b11, ADC model returns 0xA5C for ch2 → 2 frames, 1 sample_valid, chan=2, data=0xA5C; adc_din shows 010 at bits 2..4 of both frames.
- mask=8'b1000_0011, model data = 0x100+chan → samples in order ch0=0x100, ch1=0x101, ch7=0x107; 4 frames; busy drops after the last HOLD.
- continuous=1, mask=0x01, drop continuous after 3 samples → the current sweep finishes, then IDLE, div_enable=0.
- start with mask=0 → err=1, busy stays 0; next start with mask=0x01 clears err.
- Reset asserted at SHIFT bit 7 → adc_cs_n=1, adc_sclk=1, no sample_valid, state IDLE.
- With ADC_SEQ_STALL_TIMEOUT_EN, hold div_clk static after ARM → err=1 after 1024 cycles, adc_cs_n=1, busy=0.
